// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the I/D requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data side has priority; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus,
  output logic busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          i_starved;
  logic          d_win;

  assign i_starved = bus.i_req
                  && (starve_cnt == SW'(STARVE_MAX));
  assign d_win     = bus.d_req && !i_starved;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= {DATA_W{1'b0}};
      bus.d_rdata <= {DATA_W{1'b0}};
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= {ADDR_W{1'b0}};
      bus.m_wdata <= {DATA_W{1'b0}};
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_win) begin
            state       <= GNT_D;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
            // count only D wins that kept a pending fetch waiting
            if (!bus.i_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (bus.i_req) begin
            state       <= GNT_I;
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= {DATA_W{1'b0}};
            starve_cnt  <= '0;
          end
        end
        GNT_I: begin
          if (bus.m_ack) begin
            state       <= RESP;
            bus.m_req   <= 1'b0;
            bus.i_rdata <= bus.m_rdata;
            bus.i_ack   <= 1'b1;
          end
        end
        GNT_D: begin
          if (bus.m_ack) begin
            state     <= RESP;
            bus.m_req <= 1'b0;
            bus.d_ack <= 1'b1;
            if (!bus.m_we)
              bus.d_rdata <= bus.m_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/fetch cases, then randomized
// I/D traffic against a memory model with a scoreboard and grant-order model.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(SM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic void fail(string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endfunction

  logic [31:0] mem [128];
  logic [31:0] refmem [128];
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  logic        gseq [$];

  bit mem_en  = 0;
  bit mon_en  = 0;
  int lat_max = 0;
  int cnt     = -1;

  // memory responder with random ack latency
  always begin
    @(posedge clk);
    #1;
    if (mem_en) begin
      bus.m_ack = 1'b0;
      if (bus.m_req) begin
        if (cnt < 0) cnt = $urandom_range(0, lat_max);
        if (cnt == 0) begin
          bus.m_ack = 1'b1;
          if (bus.m_we) begin
            mem[bus.m_addr[8:2]] = bus.m_wdata;
            bus.m_rdata = $urandom;
          end else begin
            bus.m_rdata = mem[bus.m_addr[8:2]];
          end
          cnt = -1;
        end else begin
          cnt--;
        end
      end else begin
        cnt = -1;
      end
    end
  end

  logic        p_mreq, p_ireq, p_dreq, p_dwe, p_iack, p_dack;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic [48:0] g_fields;
  int          starve_m = 0;

  // monitor: grant-order model, hold stability, ack scoreboard
  always @(negedge clk) begin
    if (rst) starve_m = 0;
    if (mon_en && !rst) begin
      chk("busy", 64'(busy), 64'(bus.m_req | bus.i_ack | bus.d_ack));
      if (bus.m_req && !p_mreq) begin
        logic exp_d;
        exp_d = p_dreq && !(p_ireq && starve_m == SM);
        chk("grant_kind", 64'(bus.m_addr[8]), 64'(exp_d));
        gseq.push_back(bus.m_addr[8]);
        if (exp_d) begin
          chk("gnt_d_addr", 64'(bus.m_addr), 64'(p_daddr));
          chk("gnt_d_we", 64'(bus.m_we), 64'(p_dwe));
          if (p_dwe) chk("gnt_d_wdata", 64'(bus.m_wdata), 64'(p_dwdata));
          starve_m = p_ireq ? ((starve_m < SM) ? starve_m + 1 : SM) : 0;
        end else begin
          chk("gnt_i_addr", 64'(bus.m_addr), 64'(p_iaddr));
          chk("gnt_i_we", 64'(bus.m_we), 64'(0));
          starve_m = 0;
        end
        g_fields = {bus.m_we, bus.m_addr[15:0], bus.m_wdata};
      end else if (bus.m_req) begin
        chk("m_hold", 64'({bus.m_we, bus.m_addr[15:0], bus.m_wdata}),
            64'(g_fields));
      end
      if (bus.i_ack) begin
        chk("i_ack_pulse", 64'(p_iack), 64'(0));
        if (iq.size() == 0) fail("i_ack_unexpected");
        else chk("i_rdata", 64'(bus.i_rdata), 64'(iq.pop_front()));
      end
      if (bus.d_ack) begin
        chk("d_ack_pulse", 64'(p_dack), 64'(0));
        if (dq.size() == 0) fail("d_ack_unexpected");
        else chk("d_rdata", 64'(bus.d_rdata), 64'(dq.pop_front()));
      end
    end
    p_mreq   = bus.m_req;
    p_ireq   = bus.i_req;
    p_dreq   = bus.d_req;
    p_dwe    = bus.d_we;
    p_iaddr  = bus.i_addr;
    p_daddr  = bus.d_addr;
    p_dwdata = bus.d_wdata;
    p_iack   = bus.i_ack;
    p_dack   = bus.d_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_i(int n, int gap);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) << 2;
      iq.push_back(refmem[a[8:2]]);
      bus.i_addr = a;
      bus.i_req  = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!bus.i_ack && t < 200);
      if (!bus.i_ack) fail("i_timeout");
      if (gap > 0) begin
        bus.i_req = 1'b0;
        repeat ($urandom_range(0, gap)) tick();
      end
    end
    bus.i_req = 1'b0;
  endtask

  logic [31:0] last_rd = '0;

  task automatic run_d(int n, int gap);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [31:0] a;
      logic [31:0] w;
      logic        we;
      a  = 32'h100 | (32'($urandom_range(0, 63)) << 2);
      w  = $urandom;
      we = 1'($urandom_range(0, 1));
      if (we) begin
        refmem[a[8:2]] = w;
      end else begin
        last_rd = refmem[a[8:2]];
      end
      dq.push_back(last_rd);
      bus.d_addr  = a;
      bus.d_wdata = w;
      bus.d_we    = we;
      bus.d_req   = 1'b1;
      t = 0;
      do begin tick(); t++; end while (!bus.d_ack && t < 200);
      if (!bus.d_ack) fail("d_timeout");
      if (gap > 0) begin
        bus.d_req = 1'b0;
        repeat ($urandom_range(0, gap)) tick();
      end
    end
    bus.d_req = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return {bus.i_ack, bus.d_ack, bus.m_req, bus.m_we, busy,
            bus.m_addr[7:0], bus.m_wdata[7:0],
            bus.i_rdata[15:0], bus.d_rdata[15:0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] seq;
    for (int k = 0; k < 128; k++) begin
      mem[k]    = $urandom;
      refmem[k] = mem[k];
    end
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 0; bus.m_rdata = '0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outs", outs(), 64'(0));

    // abandon a stalled D write with a reset, then send a stray m_ack
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 32'h10; bus.d_wdata = 32'hdeadbeef;
    tick();
    chk("rst_gnt_d", 64'({bus.m_req, bus.m_we, bus.m_addr}),
        64'({2'b11, 32'h10}));
    tick();
    rst = 1'b1; bus.d_req = 0;
    tick();
    rst = 1'b0;
    chk("rst_mid_outs", outs(), 64'(0));
    bus.m_ack = 1; bus.m_rdata = 32'h12345678;
    tick();
    bus.m_ack = 0;
    chk("late_ack_ignored", outs(), 64'(0));
    tick();
    chk("late_ack_idle", outs(), 64'(0));

    // lone fetch with same-cycle memory ack
    bus.i_req = 1; bus.i_addr = 32'h2c;
    tick();
    chk("fetch_c1", 64'({bus.m_req, bus.m_we, bus.i_ack, bus.m_addr}),
        64'({3'b100, 32'h2c}));
    bus.m_ack = 1; bus.m_rdata = 32'h00500093;
    tick();
    bus.m_ack = 0; bus.i_req = 0;
    chk("fetch_c2", 64'({bus.i_ack, bus.m_req, bus.i_rdata}),
        64'({2'b10, 32'h00500093}));
    tick();
    chk("fetch_c3", 64'({bus.i_ack, busy, bus.i_rdata}),
        64'({2'b00, 32'h00500093}));

    // random traffic
    mem_en = 1; mon_en = 1; lat_max = 3;
    tick();
    fork
      run_i(40, 3);
      run_d(40, 3);
    join
    repeat (10) tick();

    // both held, zero latency: starvation guard pattern
    lat_max = 0;
    gseq.delete();
    fork
      run_i(3, 0);
      run_d(14, 0);
    join
    repeat (10) tick();
    seq = '0;
    for (int k = 0; k < 11; k++)
      if (k < gseq.size()) seq = {seq[9:0], gseq[k]};
    chk("starve_seq", 64'(seq), 64'(11'b11110111101));

    // back-to-back fetches with i_req never dropped
    fork
      run_i(8, 0);
    join
    repeat (6) tick();

    chk("iq_drained", 64'(iq.size()), 64'(0));
    chk("dq_drained", 64'(dq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
